regbank_mp: RTL

//   Parametrised multi-port register bank for the CPU datapath: NRD combinational

---
 rtl/regbank_mp_if.sv | 44 ++++
 rtl/regbank_mp.sv | 116 +++++++++++
 2 files changed

// File: rtl/regbank_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_mp_if
//  Brief    : Bus bundle for the multi-port register bank: read ports,
//             two write ports, stack-pointer controls and busy scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
interface regbank_mp_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned NRD = 2
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [DW-1:0]     wd0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [DW-1:0]     wd1;
  logic              sp_push;
  logic              sp_pop;
  logic [DW-1:0]     sp;
  logic              sp_err;
  logic              busy_set;
  logic [AW-1:0]     busy_addr;
  logic [DW-1:0]     last_wd;

  // Datapath / issue-stage side.
  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1,
           sp_push, sp_pop, busy_set, busy_addr,
    input  rd_data, rd_busy, sp, sp_err, last_wd
  );

  // Register bank side.
  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1,
           sp_push, sp_pop, busy_set, busy_addr,
    output rd_data, rd_busy, sp, sp_err, last_wd
  );
endinterface
`default_nettype wire

// File: rtl/regbank_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_mp
//  Brief    : Multi-port register bank: NRD combinational read ports, two
//             write ports (port 1 has priority), hardwired-zero R0, stack
//             pointer with bounded push/pop and a per-register busy scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module regbank_mp #(
  parameter int unsigned DW       = 32,
  parameter int unsigned NREG     = 17,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned SP_IDX   = 16,
  parameter int unsigned SP_RESET = 1023,
  parameter int unsigned SP_MIN   = 0,
  parameter int unsigned SP_STEP  = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  regbank_mp_if.slave   bus
);

  localparam logic [DW-1:0] c_SP_RESET = DW'(SP_RESET);
  localparam logic [DW-1:0] c_SP_MIN   = DW'(SP_MIN);
  localparam logic [DW-1:0] c_SP_STEP  = DW'(SP_STEP);

  // A real, writable register: not R0 and inside the bank.
  function automatic logic f_addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREG);
  endfunction

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [DW-1:0]   last_wd_q, last_wd_d;
  logic            sp_err_q, sp_err_d;

  // Writes in a reset cycle are dropped, so they are also never forwarded.
  logic w_we0_ok, w_we1_ok, w_sp_wr, w_set_ok;
  assign w_we0_ok = !rst && bus.we0 && f_addr_ok(bus.wa0);
  assign w_we1_ok = !rst && bus.we1 && f_addr_ok(bus.wa1);
  assign w_sp_wr  = (w_we0_ok && (32'(bus.wa0) == SP_IDX)) ||
                    (w_we1_ok && (32'(bus.wa1) == SP_IDX));
  assign w_set_ok = !rst && bus.busy_set && f_addr_ok(bus.busy_addr);

  // Next state: writes (port 1 applied last so it wins), SP adjust, scoreboard.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    last_wd_d = last_wd_q;
    sp_err_d  = 1'b0;

    if (w_we0_ok) begin
      regs_d[bus.wa0] = bus.wd0;
      busy_d[bus.wa0] = 1'b0;
      last_wd_d       = bus.wd0;
    end
    if (w_we1_ok) begin
      regs_d[bus.wa1] = bus.wd1;
      busy_d[bus.wa1] = 1'b0;
      last_wd_d       = bus.wd1;
    end

    // An explicit SP write takes precedence over push/pop and their errors.
    if (!rst && !w_sp_wr) begin
      if (bus.sp_push && !bus.sp_pop) begin
        if (regs_q[SP_IDX] == c_SP_MIN) sp_err_d = 1'b1;
        else regs_d[SP_IDX] = regs_q[SP_IDX] - c_SP_STEP;
      end else if (bus.sp_pop && !bus.sp_push) begin
        if (regs_q[SP_IDX] == c_SP_RESET) sp_err_d = 1'b1;
        else regs_d[SP_IDX] = regs_q[SP_IDX] + c_SP_STEP;
      end
    end

    // A new producer outranks a completing one on the same register.
    if (w_set_ok) busy_d[bus.busy_addr] = 1'b1;
  end

  // State registers with synchronous reset; SP comes up at its empty bound.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      regs_q[SP_IDX] <= c_SP_RESET;
      busy_q         <= '0;
      last_wd_q      <= '0;
      sp_err_q       <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      last_wd_q <= last_wd_d;
      sp_err_q  <= sp_err_d;
    end
  end

  // Combinational read ports with optional write forwarding.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_ok;
    assign w_addr = bus.rd_addr[k*AW +: AW];
    assign w_ok   = f_addr_ok(w_addr);
    assign bus.rd_data[k*DW +: DW] =
        !w_ok                                                  ? '0      :
        ((BYPASS != 0) && w_we1_ok && (bus.wa1 == w_addr))     ? bus.wd1 :
        ((BYPASS != 0) && w_we0_ok && (bus.wa0 == w_addr))     ? bus.wd0 :
                                                                 regs_q[w_addr];
    assign bus.rd_busy[k] = w_ok && busy_q[w_addr];
  end

  assign bus.sp      = regs_q[SP_IDX];
  assign bus.sp_err  = sp_err_q;
  assign bus.last_wd = last_wd_q;

endmodule
`default_nettype wire
